line_buffer_fifo: RTL and testbench

//  Single-clock, line-granular video FIFO. Generalises the 5-line/720-pixel buffer:

---
 rtl/line_buffer_fifo_if.sv | 38 +++
 rtl/line_buffer_fifo.sv | 121 ++++++++++++
 tb/tb_line_buffer_fifo.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/line_buffer_fifo_if.sv
// Bundle of write-side and read-side signals for line_buffer_fifo.
// The FIFO takes the slave modport; the producer/consumer pair takes master.
interface line_buffer_fifo_if #(
    parameter int DATA_W    = 8,
    parameter int NUM_LINES = 5
);
    localparam int CNT_W = $clog2(NUM_LINES + 1);

    // Write: a beat is taken on any rising edge with in_valid & in_ready & !in_abort;
    // in_ready only reflects committed lines. Read: out_read is a request, answered
    // one cycle later by out_valid (or by an underflow pulse when nothing is committed).
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_eol;
    logic              in_abort;
    logic              in_ready;
    logic              out_read;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_eol;
    logic [CNT_W-1:0]  lines_used;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output in_data, in_valid, in_eol, in_abort, out_read,
        input  in_ready, out_data, out_valid, out_eol, lines_used,
               full, empty, overflow, underflow
    );

    modport slave (
        input  in_data, in_valid, in_eol, in_abort, out_read,
        output in_ready, out_data, out_valid, out_eol, lines_used,
               full, empty, overflow, underflow
    );
endinterface

// File: rtl/line_buffer_fifo.sv
// Line-granular video FIFO: whole lines are committed on eol (or when a line fills),
// replayed with their stored length, and only committed lines are visible to the reader.
module line_buffer_fifo #(
    parameter int DATA_W    = 8,
    parameter int LINE_LEN  = 720,
    parameter int NUM_LINES = 5
) (
    input  logic clock,
    input  logic reset,
    line_buffer_fifo_if.slave bus
);
    localparam int PX_W  = $clog2(LINE_LEN);
    localparam int LN_W  = $clog2(NUM_LINES);
    localparam int CNT_W = $clog2(NUM_LINES + 1);

    localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(LINE_LEN - 1);
    localparam logic [LN_W-1:0]  LN_LAST  = LN_W'(NUM_LINES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_LINES);

    logic [DATA_W-1:0] r_mem [NUM_LINES][LINE_LEN];
    logic [PX_W-1:0]   r_len [NUM_LINES];

    logic [LN_W-1:0]   r_wr_line;
    logic [PX_W-1:0]   r_wr_px;
    logic [LN_W-1:0]   r_rd_line;
    logic [PX_W-1:0]   r_rd_px;
    logic [CNT_W-1:0]  r_lines_used;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_eol;
    logic              r_overflow;
    logic              r_underflow;

    logic w_in_ready;
    logic w_empty;
    logic w_full;
    logic w_wr_acc;
    logic w_commit;
    logic w_rd_acc;
    logic w_rd_last;
    logic w_release;

    assign w_in_ready = (r_lines_used < CNT_FULL);
    assign w_empty    = (r_lines_used == '0);
    assign w_full     = (r_lines_used == CNT_FULL);

    assign w_wr_acc  = bus.in_valid & w_in_ready & ~bus.in_abort;
    assign w_commit  = w_wr_acc & (bus.in_eol | (r_wr_px == PX_LAST));
    assign w_rd_acc  = bus.out_read & ~w_empty;
    assign w_rd_last = (r_rd_px == r_len[r_rd_line]);
    assign w_release = w_rd_acc & w_rd_last;

    // Storage is never reset; the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (w_wr_acc) begin
            r_mem[r_wr_line][r_wr_px] <= bus.in_data;
        end
        if (w_commit) begin
            r_len[r_wr_line] <= r_wr_px;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_line    <= '0;
            r_wr_px      <= '0;
            r_rd_line    <= '0;
            r_rd_px      <= '0;
            r_lines_used <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_eol    <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            // Abort wins over a same-cycle beat; the beat is silently discarded.
            if (bus.in_abort) begin
                r_wr_px <= '0;
            end else if (w_commit) begin
                r_wr_px   <= '0;
                r_wr_line <= (r_wr_line == LN_LAST) ? '0 : r_wr_line + LN_W'(1);
            end else if (w_wr_acc) begin
                r_wr_px <= r_wr_px + PX_W'(1);
            end

            if (w_rd_acc) begin
                r_out_data <= r_mem[r_rd_line][r_rd_px];
                r_out_eol  <= w_rd_last;
                if (w_rd_last) begin
                    r_rd_px   <= '0;
                    r_rd_line <= (r_rd_line == LN_LAST) ? '0 : r_rd_line + LN_W'(1);
                end else begin
                    r_rd_px <= r_rd_px + PX_W'(1);
                end
            end else begin
                r_out_eol <= 1'b0;
            end

            // A commit and a release in the same cycle cancel out.
            if (w_commit && !w_release) begin
                r_lines_used <= r_lines_used + CNT_W'(1);
            end else if (w_release && !w_commit) begin
                r_lines_used <= r_lines_used - CNT_W'(1);
            end

            r_out_valid <= w_rd_acc;
            r_overflow  <= bus.in_valid & ~w_in_ready & ~bus.in_abort;
            r_underflow <= bus.out_read & w_empty;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_eol    = r_out_eol;
    assign bus.lines_used = r_lines_used;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.overflow   = r_overflow;
    assign bus.underflow  = r_underflow;
endmodule

// File: tb/tb_line_buffer_fifo.sv
// Directed bench for line_buffer_fifo with DATA_W=8, LINE_LEN=8, NUM_LINES=5.
module tb_line_buffer_fifo;
    logic clock;
    logic reset;

    int n_checks;
    int n_errors;
    logic [8:0] exp_q[$];
    int popped;

    line_buffer_fifo_if #(.DATA_W(8), .NUM_LINES(5)) bus ();

    line_buffer_fifo #(
        .DATA_W(8),
        .LINE_LEN(8),
        .NUM_LINES(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d, input logic eol);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_eol   = eol;
        step();
        bus.in_valid = 1'b0;
        bus.in_eol   = 1'b0;
    endtask

    task automatic read_word(input string tag, input logic [7:0] d, input logic eol);
        bus.out_read = 1'b1;
        step();
        bus.out_read = 1'b0;
        check({tag, "_valid"}, bus.out_valid, 1'b1);
        check({tag, "_data"}, bus.out_data, d);
        check({tag, "_eol"}, bus.out_eol, eol);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        popped       = 0;
        reset        = 1'b1;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_eol   = 1'b0;
        bus.in_abort = 1'b0;
        bus.out_read = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_empty", bus.empty, 1'b1);
        check("rst_full", bus.full, 1'b0);
        check("rst_ready", bus.in_ready, 1'b1);
        check("rst_used", bus.lines_used, 0);
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_data", bus.out_data, 0);
        check("rst_ovf", bus.overflow, 1'b0);
        check("rst_unf", bus.underflow, 1'b0);

        // 1: full-length line without eol is committed by length
        for (int i = 0; i < 8; i++) begin
            write_word(8'h10 + 8'(i), 1'b0);
            if (i == 6) check("t1_empty_before", bus.empty, 1'b1);
        end
        check("t1_empty_after", bus.empty, 1'b0);
        check("t1_used", bus.lines_used, 1);
        for (int i = 0; i < 8; i++) read_word("t1_rd", 8'h10 + 8'(i), i == 7);
        check("t1_empty_end", bus.empty, 1'b1);

        // 2: short line ended by eol
        write_word(8'hA0, 1'b0);
        write_word(8'hA1, 1'b0);
        write_word(8'hA2, 1'b1);
        check("t2_used1", bus.lines_used, 1);
        read_word("t2_rd0", 8'hA0, 1'b0);
        read_word("t2_rd1", 8'hA1, 1'b0);
        read_word("t2_rd2", 8'hA2, 1'b1);
        check("t2_used0", bus.lines_used, 0);

        // 3: fill all five slots, then overflow
        for (int l = 0; l < 5; l++) begin
            write_word(8'h40 + 8'(2 * l), 1'b0);
            write_word(8'h41 + 8'(2 * l), 1'b1);
        end
        check("t3_full", bus.full, 1'b1);
        check("t3_ready", bus.in_ready, 1'b0);
        check("t3_used", bus.lines_used, 5);
        write_word(8'hEE, 1'b1);
        check("t3_ovf_pulse", bus.overflow, 1'b1);
        check("t3_used_hold", bus.lines_used, 5);
        step();
        check("t3_ovf_clear", bus.overflow, 1'b0);
        read_word("t3_l0a", 8'h40, 1'b0);
        read_word("t3_l0b", 8'h41, 1'b1);
        check("t3_ready_again", bus.in_ready, 1'b1);
        check("t3_full_clear", bus.full, 1'b0);
        check("t3_used4", bus.lines_used, 4);
        for (int l = 1; l < 5; l++) begin
            read_word("t3_la", 8'h40 + 8'(2 * l), 1'b0);
            read_word("t3_lb", 8'h41 + 8'(2 * l), 1'b1);
        end
        check("t3_empty", bus.empty, 1'b1);

        // 4: aborted partial line leaves no trace
        for (int i = 0; i < 4; i++) write_word(8'h20 + 8'(i), 1'b0);
        bus.in_abort = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h24;
        step();
        bus.in_abort = 1'b0;
        bus.in_valid = 1'b0;
        check("t4_abort_no_ovf", bus.overflow, 1'b0);
        check("t4_abort_used", bus.lines_used, 0);
        for (int i = 0; i < 8; i++) write_word(8'h30 + 8'(i), 1'b0);
        check("t4_used", bus.lines_used, 1);
        for (int i = 0; i < 8; i++) read_word("t4_rd", 8'h30 + 8'(i), i == 7);
        check("t4_used0", bus.lines_used, 0);

        // 5: streaming write of 12 three-word lines against a full-rate reader
        fork
            begin
                for (int l = 0; l < 12; l++) begin
                    for (int w = 0; w < 3; w++) begin
                        exp_q.push_back({w == 2, 8'h80 + 8'(l * 4 + w)});
                        bus.in_valid = 1'b1;
                        bus.in_data  = 8'h80 + 8'(l * 4 + w);
                        bus.in_eol   = (w == 2);
                        step();
                    end
                end
                bus.in_valid = 1'b0;
                bus.in_eol   = 1'b0;
            end
            begin
                bus.out_read = 1'b1;
                for (int c = 0; c < 42; c++) begin
                    step();
                    if (bus.out_valid) begin
                        check("t5_q_nonempty", exp_q.size() != 0, 1'b1);
                        if (exp_q.size() != 0) begin
                            logic [8:0] e;
                            e = exp_q.pop_front();
                            check("t5_data", bus.out_data, e[7:0]);
                            check("t5_eol", bus.out_eol, e[8]);
                            if (e[8] && (popped / 3) < 11) check("t5_steady", bus.lines_used, 1);
                            popped++;
                        end
                    end
                end
                bus.out_read = 1'b0;
            end
        join
        check("t5_count", popped, 36);
        check("t5_drained", exp_q.size(), 0);
        check("t5_used0", bus.lines_used, 0);

        // 6: underflow, then reset in the middle of a line
        bus.out_read = 1'b1;
        step();
        bus.out_read = 1'b0;
        check("t6_unf_pulse", bus.underflow, 1'b1);
        check("t6_unf_valid", bus.out_valid, 1'b0);
        check("t6_data_hold", bus.out_data, 8'hAE);
        step();
        check("t6_unf_clear", bus.underflow, 1'b0);
        write_word(8'h51, 1'b1);
        write_word(8'h52, 1'b0);
        write_word(8'h53, 1'b0);
        check("t6_used_pre", bus.lines_used, 1);
        reset        = 1'b1;
        bus.out_read = 1'b1;
        step();
        reset        = 1'b0;
        bus.out_read = 1'b0;
        check("t6_rst_empty", bus.empty, 1'b1);
        check("t6_rst_ready", bus.in_ready, 1'b1);
        check("t6_rst_used", bus.lines_used, 0);
        check("t6_rst_valid", bus.out_valid, 1'b0);
        check("t6_rst_data", bus.out_data, 0);
        write_word(8'h61, 1'b0);
        write_word(8'h62, 1'b1);
        read_word("t6_post0", 8'h61, 1'b0);
        read_word("t6_post1", 8'h62, 1'b1);
        check("t6_post_empty", bus.empty, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
